// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin sharing of one line-wide memory bus between icache and dcache
module mem_bus_arbiter #(
    parameter int AddrWidth     = 64,
    parameter int ClWidth       = 512,
    parameter int ClOffsetWidth = 6,
    parameter int TimeoutCycles = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_req,
    input  logic [AddrWidth-1:0] i_addr,
    output logic                 i_ack,
    output logic [ClWidth-1:0]   i_data,
    output logic                 i_done,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [AddrWidth-1:0] d_addr,
    input  logic [ClWidth-1:0]   d_wdata,
    output logic                 d_ack,
    output logic [ClWidth-1:0]   d_rdata,
    output logic                 d_done,
    output logic                 m_req,
    input  logic                 m_ack,
    output logic                 m_we,
    output logic [AddrWidth-1:0] m_addr,
    output logic [ClWidth-1:0]   m_wdata,
    input  logic [ClWidth-1:0]   m_rdata,
    input  logic                 m_done,
    output logic                 busy,
    output logic                 owner,
    output logic                 timeout_err
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    localparam int CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles - 1);
    localparam logic [AddrWidth-1:0] AlignMask = {AddrWidth{1'b1}} << ClOffsetWidth;
    state_t state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic last_q, last_d, win;
    logic m_req_q, m_req_d, m_we_q, m_we_d;
    logic [AddrWidth-1:0] m_addr_q, m_addr_d;
    logic [ClWidth-1:0] m_wdata_q, m_wdata_d, i_data_q, i_data_d, d_rdata_q, d_rdata_d;
    logic i_ack_q, i_ack_d, d_ack_q, d_ack_d, i_done_q, i_done_d, d_done_q, d_done_d;
    logic owner_q, owner_d, terr_q, terr_d;
    assign i_ack       = i_ack_q;
    assign d_ack       = d_ack_q;
    assign i_done      = i_done_q;
    assign d_done      = d_done_q;
    assign i_data      = i_data_q;
    assign d_rdata     = d_rdata_q;
    assign m_req       = m_req_q;
    assign m_we        = m_we_q;
    assign m_addr      = m_addr_q;
    assign m_wdata     = m_wdata_q;
    assign owner       = owner_q;
    assign timeout_err = terr_q;
    assign busy        = state_q != IDLE;
    assign win         = d_req & (~i_req | ~last_q);
    // next-state logic: grant in IDLE, track bus handshake and timeout, pulse done in RESP
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        m_req_d   = m_req_q;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        i_data_d  = i_data_q;
        d_rdata_d = d_rdata_q;
        owner_d   = owner_q;
        terr_d    = terr_q;
        i_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        i_done_d  = 1'b0;
        d_done_d  = 1'b0;
        case (state_q)
            IDLE: if (i_req | d_req) begin
                m_addr_d  = (win ? d_addr : i_addr) & AlignMask;
                m_we_d    = win & d_we;
                m_wdata_d = win ? d_wdata : '0;
                m_req_d   = 1'b1;
                i_ack_d   = ~win;
                d_ack_d   = win;
                owner_d   = win;
                last_d    = win;
                cnt_d     = '0;
                state_d   = ISSUE;
            end
            ISSUE, WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (m_done) begin
                    m_req_d   = 1'b0;
                    state_d   = RESP;
                    i_data_d  = owner_q ? i_data_q : m_rdata;
                    d_rdata_d = (owner_q && !m_we_q) ? m_rdata : d_rdata_q;
                end else if (TimeoutCycles != 0 && cnt_q == CntMax) begin
                    m_req_d   = 1'b0;
                    terr_d    = 1'b1;
                    state_d   = RESP;
                    i_data_d  = owner_q ? i_data_q : '0;
                    d_rdata_d = (owner_q && !m_we_q) ? '0 : d_rdata_q;
                end else if (state_q == ISSUE && m_ack) begin
                    m_req_d = 1'b0;
                    state_d = WAIT;
                end
            end
            RESP: begin
                i_done_d = ~owner_q;
                d_done_d = owner_q;
                state_d  = IDLE;
            end
        endcase
    end
    // all state and outputs registered; async reset clears everything, dcache counts as last served
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_q    <= 1'b1;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            i_data_q  <= '0;
            d_rdata_q <= '0;
            owner_q   <= 1'b0;
            terr_q    <= 1'b0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            i_data_q  <= i_data_d;
            d_rdata_q <= d_rdata_d;
            owner_q   <= owner_d;
            terr_q    <= terr_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
            i_done_q  <= i_done_d;
            d_done_q  <= d_done_d;
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed scenario tests for mem_bus_arbiter
module tb_mem_bus_arbiter;
    logic clk = 1'b0, rst_n = 1'b0;
    logic i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, m_ack = 1'b0, m_done = 1'b0;
    logic [63:0] i_addr = '0, d_addr = '0;
    logic [511:0] d_wdata = '0, m_rdata = '0;
    logic i_ack, i_done, d_ack, d_done, m_req, m_we, busy, owner, timeout_err;
    logic [511:0] i_data, d_rdata, m_wdata;
    logic [63:0] m_addr;
    int checks = 0, failures = 0;
    localparam logic [511:0] AA = {64{8'hAA}};
    localparam logic [511:0] L55 = {64{8'h55}};
    localparam logic [511:0] L33 = {64{8'h33}};
    localparam logic [511:0] L77 = {64{8'h77}};
    localparam logic [511:0] L99 = {64{8'h99}};

    mem_bus_arbiter #(.TimeoutCycles(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_data(i_data), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_done(d_done),
        .m_req(m_req), .m_ack(m_ack), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_done(m_done),
        .busy(busy), .owner(owner), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++; if ({i_ack, d_ack, i_done, d_done, m_req, m_we, busy, owner, timeout_err} !== 9'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0", {i_ack, d_ack, i_done, d_done, m_req, m_we, busy, owner, timeout_err}); end
        checks++; if (m_addr !== 64'h0) begin failures++; $display("FAIL reset_m_addr got=%0h exp=0", m_addr); end
        checks++; if ((i_data | d_rdata | m_wdata) !== 512'h0) begin failures++; $display("FAIL reset_data got=%0h exp=0", i_data | d_rdata | m_wdata); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_icache_fill();
        i_req = 1'b1; i_addr = 64'h1040;
        tick();
        checks++; if ({i_ack, d_ack, m_req, m_we, busy, owner} !== 6'b101010) begin failures++; $display("FAIL ifill_grant got=%b exp=101010", {i_ack, d_ack, m_req, m_we, busy, owner}); end
        checks++; if (m_addr !== 64'h1040) begin failures++; $display("FAIL ifill_addr got=%0h exp=1040", m_addr); end
        i_req = 1'b0; m_ack = 1'b1;
        tick();
        m_ack = 1'b0;
        checks++; if ({i_ack, m_req, busy} !== 3'b001) begin failures++; $display("FAIL ifill_acked got=%b exp=001", {i_ack, m_req, busy}); end
        tick();
        tick();
        m_done = 1'b1; m_rdata = AA;
        tick();
        m_done = 1'b0; m_rdata = '0;
        checks++; if (i_data !== AA || i_done !== 1'b0) begin failures++; $display("FAIL ifill_data got=%0h/%b exp=aa../0", i_data, i_done); end
        tick();
        checks++; if ({i_done, d_done, busy} !== 3'b100) begin failures++; $display("FAIL ifill_done got=%b exp=100", {i_done, d_done, busy}); end
        tick();
        checks++; if (i_done !== 1'b0 || i_data !== AA) begin failures++; $display("FAIL ifill_after got=%b/%0h exp=0/aa..", i_done, i_data); end
    endtask

    task automatic test_dcache_writeback();
        d_req = 1'b1; d_we = 1'b1; d_addr = 64'h2000; d_wdata = L55;
        tick();
        d_req = 1'b0;
        checks++; if ({i_ack, d_ack, m_req, m_we, owner} !== 5'b01111) begin failures++; $display("FAIL wb_grant got=%b exp=01111", {i_ack, d_ack, m_req, m_we, owner}); end
        checks++; if (m_wdata !== L55 || m_addr !== 64'h2000) begin failures++; $display("FAIL wb_bus got=%0h/%0h exp=55../2000", m_wdata, m_addr); end
        m_ack = 1'b1;
        tick();
        m_ack = 1'b0; m_done = 1'b1; m_rdata = L33;
        tick();
        m_done = 1'b0;
        tick();
        checks++; if ({d_done, i_done} !== 2'b10) begin failures++; $display("FAIL wb_done got=%b exp=10", {d_done, i_done}); end
        checks++; if (d_rdata !== 512'h0) begin failures++; $display("FAIL wb_rdata got=%0h exp=0", d_rdata); end
        d_we = 1'b0;
        tick();
    endtask

    task automatic test_unaligned();
        i_req = 1'b1; i_addr = 64'h107F;
        tick();
        i_req = 1'b0;
        checks++; if (m_addr !== 64'h1040 || i_ack !== 1'b1) begin failures++; $display("FAIL unaligned got=%0h/%b exp=1040/1", m_addr, i_ack); end
        m_ack = 1'b1;
        tick();
        m_ack = 1'b0; m_done = 1'b1;
        tick();
        m_done = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_win;
        exp_win = 4'b1010;
        do_reset();
        i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; i_addr = 64'h7000; d_addr = 64'h8000; m_rdata = L77;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if ({i_ack, d_ack, owner} !== {~exp_win[k], exp_win[k], exp_win[k]}) begin failures++; $display("FAIL rr_grant%0d got=%b exp=%b", k, {i_ack, d_ack, owner}, {~exp_win[k], exp_win[k], exp_win[k]}); end
            checks++; if (m_addr !== (exp_win[k] ? 64'h8000 : 64'h7000)) begin failures++; $display("FAIL rr_addr%0d got=%0h", k, m_addr); end
            if (k == 3) begin i_req = 1'b0; d_req = 1'b0; end
            m_ack = 1'b1;
            tick();
            m_ack = 1'b0; m_done = 1'b1;
            tick();
            m_done = 1'b0;
            tick();
            checks++; if ({i_done, d_done} !== {~exp_win[k], exp_win[k]}) begin failures++; $display("FAIL rr_done%0d got=%b", k, {i_done, d_done}); end
        end
        m_rdata = '0;
        tick();
    endtask

    task automatic test_timeout();
        i_req = 1'b1; i_addr = 64'h3000;
        tick();
        i_req = 1'b0; m_ack = 1'b1;
        checks++; if (i_ack !== 1'b1 || i_data !== L77) begin failures++; $display("FAIL to_grant got=%b/%0h exp=1/77..", i_ack, i_data); end
        tick();
        m_ack = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        checks++; if ({busy, timeout_err, m_req} !== 3'b100) begin failures++; $display("FAIL to_pending got=%b exp=100", {busy, timeout_err, m_req}); end
        tick();
        checks++; if ({timeout_err, m_req, i_done} !== 3'b100 || i_data !== 512'h0) begin failures++; $display("FAIL to_abort got=%b/%0h exp=100/0", {timeout_err, m_req, i_done}, i_data); end
        tick();
        checks++; if ({i_done, d_done, busy} !== 3'b100) begin failures++; $display("FAIL to_done got=%b exp=100", {i_done, d_done, busy}); end
        m_done = 1'b1; m_rdata = AA;
        tick();
        m_done = 1'b0;
        tick();
        checks++; if ({i_done, d_done, busy, timeout_err} !== 4'b0001 || i_data !== 512'h0) begin failures++; $display("FAIL to_stray got=%b/%0h exp=0001/0", {i_done, d_done, busy, timeout_err}, i_data); end
    endtask

    task automatic test_same_cycle_and_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h4000;
        tick();
        d_req = 1'b0; m_ack = 1'b1; m_done = 1'b1; m_rdata = L99;
        tick();
        m_ack = 1'b0; m_done = 1'b0;
        checks++; if (d_rdata !== L99 || d_done !== 1'b0 || m_req !== 1'b0) begin failures++; $display("FAIL same_capture got=%0h/%b/%b exp=99../0/0", d_rdata, d_done, m_req); end
        tick();
        checks++; if ({d_done, i_done} !== 2'b10) begin failures++; $display("FAIL same_done got=%b exp=10", {d_done, i_done}); end
        tick();
        i_req = 1'b1; i_addr = 64'h5000;
        tick();
        i_req = 1'b0; m_ack = 1'b1;
        tick();
        m_ack = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        checks++; if ({m_req, busy, i_ack, i_done, d_done, owner, timeout_err} !== 7'b0) begin failures++; $display("FAIL midreset_flags got=%b exp=0", {m_req, busy, i_ack, i_done, d_done, owner, timeout_err}); end
        checks++; if ((i_data | d_rdata | m_wdata) !== 512'h0 || m_addr !== 64'h0) begin failures++; $display("FAIL midreset_data got=%0h exp=0", i_data | d_rdata); end
        m_done = 1'b1;
        tick();
        m_done = 1'b0;
        rst_n = 1'b1;
        tick();
        checks++; if ({i_done, d_done, busy} !== 3'b000) begin failures++; $display("FAIL postreset_idle got=%b exp=000", {i_done, d_done, busy}); end
        i_req = 1'b1; i_addr = 64'h6000;
        tick();
        i_req = 1'b0;
        checks++; if (i_ack !== 1'b1 || m_addr !== 64'h6000 || m_req !== 1'b1) begin failures++; $display("FAIL postreset_grant got=%b/%0h/%b exp=1/6000/1", i_ack, m_addr, m_req); end
    endtask

    initial begin
        test_reset();
        test_icache_fill();
        test_dcache_writeback();
        test_unaligned();
        test_round_robin();
        test_timeout();
        test_same_cycle_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
